// File: rtl/decoding_stage_if.sv
// rtl/decoding_stage_if.sv - start/result handshakes, PE status and stage broadcast for decoding_stage_controller
// DECODING_STAGE_CYCLE_COUNT_EN adds the cycle_count signal to both modports.
interface decoding_stage_if #(
  parameter int STAGE_WIDTH = 3,
  parameter int ITER_WIDTH  = 8
);
  logic                   start_valid;
  logic                   start_ready;
  logic                   busy_any;
  logic                   odd_any;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic                   result_valid;
  logic                   result_ready;
  logic [ITER_WIDTH-1:0]  grow_iterations;
  logic                   timeout;
`ifdef DECODING_STAGE_CYCLE_COUNT_EN
  logic [31:0]            cycle_count;

  modport master (
    input  start_valid, busy_any, odd_any, result_ready,
    output start_ready, global_stage, result_valid, grow_iterations, timeout, cycle_count
  );
  modport slave (
    output start_valid, busy_any, odd_any, result_ready,
    input  start_ready, global_stage, result_valid, grow_iterations, timeout, cycle_count
  );
`else
  modport master (
    input  start_valid, busy_any, odd_any, result_ready,
    output start_ready, global_stage, result_valid, grow_iterations, timeout
  );
  modport slave (
    output start_valid, busy_any, odd_any, result_ready,
    input  start_ready, global_stage, result_valid, grow_iterations, timeout
  );
`endif
endinterface

// File: rtl/decoding_stage_controller.sv
// rtl/decoding_stage_controller.sv - round sequencer: load, grow/merge loop, peel, result
// Optional DECODING_STAGE_CYCLE_COUNT_EN enables the per-round cycle_count output.
module decoding_stage_controller #(
  parameter int LOAD_CYCLES   = 2,
  parameter int GROW_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int STABLE_CYCLES = 2,
  parameter int MAX_ITER      = 255,
  parameter int ITER_WIDTH    = 8,
  parameter int STAGE_WIDTH   = 3
) (
  input  logic              clk,
  input  logic              reset,
  decoding_stage_if.master  bus
);
  localparam int CNT_W = 8;
  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = STAGE_WIDTH'(0);
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = STAGE_WIDTH'(1);
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = STAGE_WIDTH'(2);
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = STAGE_WIDTH'(3);
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = STAGE_WIDTH'(4);
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = STAGE_WIDTH'(5);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GROW, S_MERGE, S_PEEL, S_RESULT} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       stable_q, stable_d;
  logic [ITER_WIDTH-1:0]  iter_q, iter_d;
  logic                   timeout_q, timeout_d;
  logic [STAGE_WIDTH-1:0] stage_q, stage_d;
  logic                   settled, converged;

  function automatic logic [STAGE_WIDTH-1:0] stage_of(state_t s);
    case (s)
      S_LOAD:   return STAGE_MEASUREMENT_LOADING;
      S_GROW:   return STAGE_GROW;
      S_MERGE:  return STAGE_MERGE;
      S_PEEL:   return STAGE_PEELING;
      S_RESULT: return STAGE_RESULT_VALID;
      default:  return STAGE_IDLE;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      stable_q  <= '0;
      iter_q    <= '0;
      timeout_q <= 1'b0;
      stage_q   <= STAGE_IDLE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      iter_q    <= iter_d;
      timeout_q <= timeout_d;
      stage_q   <= stage_d;
    end
  end

  // cnt_q times LOAD/GROW dwell and the MERGE/PEEL settle window; it holds once settled.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    iter_d    = iter_q;
    timeout_d = timeout_q;
    settled   = (cnt_q == CNT_W'(SETTLE_CYCLES));
    converged = settled && !bus.busy_any && (stable_q == CNT_W'(STABLE_CYCLES - 1));
    case (state_q)
      S_IDLE: begin
        if (bus.start_valid) begin
          state_d   = S_LOAD;
          cnt_d     = '0;
          iter_d    = '0;
          timeout_d = 1'b0;
        end
      end
      S_LOAD, S_GROW: begin
        if ((state_q == S_LOAD && cnt_q == CNT_W'(LOAD_CYCLES - 1)) ||
            (state_q == S_GROW && cnt_q == CNT_W'(GROW_CYCLES - 1))) begin
          state_d  = S_MERGE;
          cnt_d    = '0;
          stable_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MERGE, S_PEEL: begin
        if (!settled) begin
          cnt_d = cnt_q + 1'b1;
        end else if (bus.busy_any) begin
          stable_d = '0;
        end else if (!converged) begin
          stable_d = stable_q + 1'b1;
        end else begin
          cnt_d    = '0;
          stable_d = '0;
          if (state_q == S_PEEL || !bus.odd_any) begin
            state_d = (state_q == S_PEEL) ? S_RESULT : S_PEEL;
          end else if (iter_q < ITER_WIDTH'(MAX_ITER)) begin
            state_d = S_GROW;
            iter_d  = iter_q + 1'b1;
          end else begin
            state_d   = S_PEEL;
            timeout_d = 1'b1;
          end
        end
      end
      S_RESULT: begin
        if (bus.result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    stage_d = stage_of(state_d);
  end

`ifdef DECODING_STAGE_CYCLE_COUNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == S_IDLE && bus.start_valid) begin
      cyc_d = '0;
    end else if (state_q != S_IDLE && state_q != S_RESULT && cyc_q != 32'hFFFF_FFFF) begin
      cyc_d = cyc_q + 32'd1;
    end
  end
`endif

  always_comb begin
    bus.start_ready     = (state_q == S_IDLE);
    bus.result_valid    = (state_q == S_RESULT);
    bus.global_stage    = stage_q;
    bus.grow_iterations = iter_q;
    bus.timeout         = timeout_q;
`ifdef DECODING_STAGE_CYCLE_COUNT_EN
    bus.cycle_count     = cyc_q;
`endif
  end
endmodule
